// File: rtl/fir_stream_ctrl.sv
//------------------------------------------------------------------------------
// fir_stream_ctrl : streams sample RAM contents into a FIR at a programmable
//                   rate, flushes the filter tail and strobes out each result.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module fir_stream_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int OUT_WIDTH   = 38,
  parameter int ADDR_WIDTH  = 13,
  parameter int DIV_WIDTH   = 16,
  parameter int FLUSH_TAPS  = 50,
  parameter int FIR_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] num_samples,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] fir_x_in,
  input  logic [OUT_WIDTH-1:0]  fir_y_out,
  output logic                  y_valid,
  output logic [OUT_WIDTH-1:0]  y_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] sample_cnt
);

  localparam int c_flush_w   = $clog2(FLUSH_TAPS + 1);
  localparam int c_drain_cyc = FIR_LATENCY + 3;
  localparam int c_drain_w   = $clog2(c_drain_cyc + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_FLUSH = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  num_q, num_d;
  logic [DIV_WIDTH-1:0]   div_lim_q, div_lim_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic [c_flush_w-1:0]   flush_q, flush_d;
  logic [c_drain_w-1:0]   drain_q, drain_d;
  logic                   tick_q, tick_d;
  logic                   rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
  logic                   s1_vld_q, s1_vld_d;
  logic                   s1_zero_q, s1_zero_d;
  logic                   s2_vld_q, s2_vld_d;
  logic [DATA_WIDTH-1:0]  x_q, x_d;
  logic [FIR_LATENCY-1:0] lat_q, lat_d;
  logic                   yv_q, yv_d;
  logic [OUT_WIDTH-1:0]   yd_q, yd_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    div_lim_d = div_lim_q;
    div_d     = div_q;
    flush_d   = flush_q;
    drain_d   = drain_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    s1_vld_d  = 1'b0;
    s1_zero_d = 1'b0;
    s2_vld_d  = s1_vld_q;
    x_d       = x_q;
    done_d    = 1'b0;

    // A read issued this cycle is counted at the end of it.
    if (rd_en_q) cnt_d = cnt_q + ADDR_WIDTH'(1);

    // RAM data lands one cycle after the read; flush slots inject zero instead.
    if (s1_vld_q) x_d = s1_zero_q ? '0 : mem_rdata;

    lat_d[0] = s2_vld_q;
    for (int i = 1; i < FIR_LATENCY; i++) lat_d[i] = lat_q[i-1];
    yv_d = lat_q[FIR_LATENCY-1];
    yd_d = yv_d ? fir_y_out : yd_q;

    if (tick_q)              div_d = div_lim_q;
    else if (div_q != '0)    div_d = div_q - DIV_WIDTH'(1);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d     = num_samples;
          div_lim_d = clk_div;
          cnt_d     = '0;
          div_d     = '0;
          flush_d   = '0;
          drain_d   = '0;
          state_d   = (num_samples == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (tick_q) begin
          s1_vld_d = 1'b1;
          if (cnt_q + ADDR_WIDTH'(1) == num_q) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (tick_q) begin
          s1_vld_d  = 1'b1;
          s1_zero_d = 1'b1;
          if (flush_q == c_flush_w'(FLUSH_TAPS - 1)) begin
            flush_d = '0;
            state_d = S_DRAIN;
          end else begin
            flush_d = flush_q + c_flush_w'(1);
          end
        end
      end
      S_DRAIN: begin
        div_d = '0;
        if (drain_q == c_drain_w'(c_drain_cyc - 1)) begin
          drain_d = '0;
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + c_drain_w'(1);
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort drops everything in flight but keeps the read count and last y_data.
    if (abort && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      div_d    = '0;
      flush_d  = '0;
      drain_d  = '0;
      s1_vld_d = 1'b0;
      s2_vld_d = 1'b0;
      x_d      = '0;
      lat_d    = '0;
      yv_d     = 1'b0;
      yd_d     = yd_q;
      done_d   = 1'b0;
    end

    tick_d  = ((state_d == S_RUN) || (state_d == S_FLUSH)) && (div_d == '0);
    rd_en_d = (state_d == S_RUN) && (div_d == '0);
    if (rd_en_d) addr_d = cnt_d;
    busy_d  = (state_d == S_RUN) || (state_d == S_FLUSH) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      num_q     <= '0;
      div_lim_q <= '0;
      div_q     <= '0;
      flush_q   <= '0;
      drain_q   <= '0;
      tick_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      cnt_q     <= '0;
      s1_vld_q  <= 1'b0;
      s1_zero_q <= 1'b0;
      s2_vld_q  <= 1'b0;
      x_q       <= '0;
      lat_q     <= '0;
      yv_q      <= 1'b0;
      yd_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      div_lim_q <= div_lim_d;
      div_q     <= div_d;
      flush_q   <= flush_d;
      drain_q   <= drain_d;
      tick_q    <= tick_d;
      rd_en_q   <= rd_en_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      s1_vld_q  <= s1_vld_d;
      s1_zero_q <= s1_zero_d;
      s2_vld_q  <= s2_vld_d;
      x_q       <= x_d;
      lat_q     <= lat_d;
      yv_q      <= yv_d;
      yd_q      <= yd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign mem_rd_en  = rd_en_q;
  assign mem_addr   = addr_q;
  assign fir_x_in   = x_q;
  assign y_valid    = yv_q;
  assign y_data     = yd_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sample_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fir_stream_ctrl.sv
//------------------------------------------------------------------------------
// tb_fir_stream_ctrl : scoreboard bench with a RAM model and a 1-clock FIR stub.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_fir_stream_ctrl;

  localparam int DW = 16, OW = 38, AW = 13, VW = 16, TAPS = 50, LAT = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] num_samples = '0;
  logic [VW-1:0] clk_div = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] fir_x_in;
  logic [OW-1:0] fir_y_out;
  logic          y_valid;
  logic [OW-1:0] y_data;
  logic          busy;
  logic          done;
  logic [AW-1:0] sample_cnt;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  int            cyc = 0;
  int            n_assert = 0;
  int            n_fail = 0;
  logic [OW-1:0] exp_q[$];
  int            rd_addr_q[$];
  int            rd_cyc_q[$];
  int            y_cyc_q[$];
  int            done_cnt = 0;
  int            busy_cnt = 0;
  int            last_done_cyc = 0;
  int            start_cyc = 0;

  fir_stream_ctrl #(
    .DATA_WIDTH(DW), .OUT_WIDTH(OW), .ADDR_WIDTH(AW), .DIV_WIDTH(VW),
    .FLUSH_TAPS(TAPS), .FIR_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .num_samples(num_samples), .clk_div(clk_div),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .fir_x_in(fir_x_in), .fir_y_out(fir_y_out),
    .y_valid(y_valid), .y_data(y_data), .busy(busy), .done(done),
    .sample_cnt(sample_cnt)
  );

  // Memoryless filter stand-in: distinct value per sample exposes ordering.
  function automatic logic [OW-1:0] fir_f(input logic [DW-1:0] x);
    logic [OW-1:0] t;
    t = {{(OW-DW){x[DW-1]}}, x};
    return t * OW'(5) + OW'(1);
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr];
  always @(posedge clk) fir_y_out <= fir_f(fir_x_in);

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_stream(input int n, input int d);
    num_samples = AW'(n);
    clk_div     = VW'(d);
    start       = 1'b1;
    start_cyc   = cyc;
    tick();
    start       = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int i = 0; i < budget && done_cnt == d0; i++) tick();
    if (done_cnt == d0) check_eq("done_timeout", 0, 1);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_rd_en"},  64'(mem_rd_en),  0);
    check_eq({tag, "_addr"},   64'(mem_addr),   0);
    check_eq({tag, "_x"},      64'(fir_x_in),   0);
    check_eq({tag, "_yv"},     64'(y_valid),    0);
    check_eq({tag, "_yd"},     64'(y_data),     0);
    check_eq({tag, "_busy"},   64'(busy),       0);
    check_eq({tag, "_done"},   64'(done),       0);
    check_eq({tag, "_cnt"},    64'(sample_cnt), 0);
  endtask

  task automatic push_stream(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(fir_f(ram[i]));
    for (int i = 0; i < TAPS; i++) exp_q.push_back(fir_f('0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, r0, y0, b0, bad;

    fork
      forever begin
        @(negedge clk);
        if (mem_rd_en) begin
          rd_addr_q.push_back(int'(mem_addr));
          rd_cyc_q.push_back(cyc);
        end
        if (y_valid) begin
          y_cyc_q.push_back(cyc);
          if (exp_q.size() == 0) check_eq("y_unexpected", 1, 0);
          else check_eq("y_data", 64'(y_data), 64'(exp_q.pop_front()));
        end
        if (done) begin
          done_cnt++;
          last_done_cyc = cyc;
        end
        if (busy) busy_cnt++;
      end
    join_none

    // Reset and idle
    repeat (5) tick();
    check_zero("rst");
    rst = 1'b0;
    repeat (10) tick();
    check_zero("idle");
    check_eq("idle_no_y", 64'(y_cyc_q.size()), 0);
    check_eq("idle_no_done", 64'(done_cnt), 0);

    // Basic stream, one sample per clock
    ram[0] = 16'h0100; ram[1] = 16'h0200; ram[2] = 16'hFF00; ram[3] = 16'h7FFF;
    d0 = done_cnt; r0 = rd_addr_q.size(); y0 = y_cyc_q.size();
    push_stream(4);
    start_stream(4, 0);
    wait_done(d0, 400);
    repeat (2) tick();
    check_eq("basic_reads", 64'(rd_addr_q.size() - r0), 4);
    if (rd_addr_q.size() - r0 == 4) begin
      for (int i = 0; i < 4; i++) check_eq("basic_addr", 64'(rd_addr_q[r0+i]), 64'(i));
      check_eq("basic_consec", 64'(rd_cyc_q[r0+3] - rd_cyc_q[r0]), 3);
    end
    check_eq("basic_y_cnt", 64'(y_cyc_q.size() - y0), 54);
    check_eq("basic_done_cnt", 64'(done_cnt - d0), 1);
    check_eq("basic_sample_cnt", 64'(sample_cnt), 4);
    check_eq("basic_sb_empty", 64'(exp_q.size()), 0);
    check_eq("basic_x_zero", 64'(fir_x_in), 0);
    check_eq("basic_busy", 64'(busy), 0);

    // Rate divider: one sample every 10 clocks
    ram[0] = 16'h1234; ram[1] = 16'h8001; ram[2] = 16'h0042;
    d0 = done_cnt; r0 = rd_addr_q.size(); y0 = y_cyc_q.size();
    push_stream(3);
    start_stream(3, 9);
    wait_done(d0, 1000);
    repeat (2) tick();
    check_eq("div_reads", 64'(rd_addr_q.size() - r0), 3);
    if (rd_addr_q.size() - r0 == 3) begin
      check_eq("div_rd_gap0", 64'(rd_cyc_q[r0+1] - rd_cyc_q[r0]), 10);
      check_eq("div_rd_gap1", 64'(rd_cyc_q[r0+2] - rd_cyc_q[r0+1]), 10);
    end
    check_eq("div_y_cnt", 64'(y_cyc_q.size() - y0), 53);
    bad = 0;
    for (int i = y0 + 1; i < y_cyc_q.size(); i++)
      if (y_cyc_q[i] - y_cyc_q[i-1] != 10) bad++;
    check_eq("div_y_gap_bad", 64'(bad), 0);
    check_eq("div_done_cnt", 64'(done_cnt - d0), 1);
    check_eq("div_sb_empty", 64'(exp_q.size()), 0);

    // Zero-length stream
    d0 = done_cnt; r0 = rd_addr_q.size(); y0 = y_cyc_q.size(); b0 = busy_cnt;
    start_stream(0, 5);
    wait_done(d0, 20);
    repeat (2) tick();
    check_eq("zero_done_lat", 64'(last_done_cyc - start_cyc), 2);
    check_eq("zero_reads", 64'(rd_addr_q.size() - r0), 0);
    check_eq("zero_y", 64'(y_cyc_q.size() - y0), 0);
    check_eq("zero_busy", 64'(busy_cnt - b0), 0);
    check_eq("zero_done_cnt", 64'(done_cnt - d0), 1);

    // Abort during the 20th read
    for (int i = 0; i < 100; i++) ram[i] = DW'(i * 37 + 5);
    d0 = done_cnt; r0 = rd_addr_q.size(); y0 = y_cyc_q.size();
    push_stream(100);
    start_stream(100, 0);
    for (int i = 0; i < 200 && rd_addr_q.size() - r0 < 20; i++) tick();
    check_eq("abort_reached20", 64'(rd_addr_q.size() - r0), 20);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_busy", 64'(busy), 0);
    check_eq("abort_x", 64'(fir_x_in), 0);
    check_eq("abort_rd_en", 64'(mem_rd_en), 0);
    check_eq("abort_yv", 64'(y_valid), 0);
    check_eq("abort_cnt", 64'(sample_cnt), 20);
    repeat (10) tick();
    check_eq("abort_no_more_reads", 64'(rd_addr_q.size() - r0), 20);
    check_eq("abort_no_done", 64'(done_cnt - d0), 0);
    check_eq("abort_y_partial", 64'((y_cyc_q.size() - y0) < 20), 1);
    exp_q.delete();

    // Restart after abort begins again at address 0
    d0 = done_cnt; r0 = rd_addr_q.size(); y0 = y_cyc_q.size();
    push_stream(5);
    start_stream(5, 0);
    wait_done(d0, 400);
    repeat (2) tick();
    check_eq("restart_reads", 64'(rd_addr_q.size() - r0), 5);
    if (rd_addr_q.size() - r0 == 5)
      for (int i = 0; i < 5; i++) check_eq("restart_addr", 64'(rd_addr_q[r0+i]), 64'(i));
    check_eq("restart_y_cnt", 64'(y_cyc_q.size() - y0), 55);
    check_eq("restart_done_cnt", 64'(done_cnt - d0), 1);
    check_eq("restart_sample_cnt", 64'(sample_cnt), 5);

    // Start (with new settings) while running is ignored
    d0 = done_cnt; r0 = rd_addr_q.size(); y0 = y_cyc_q.size();
    push_stream(4);
    start_stream(4, 2);
    tick();
    num_samples = AW'(9);
    clk_div     = VW'(0);
    start       = 1'b1;
    tick();
    start       = 1'b0;
    wait_done(d0, 600);
    repeat (2) tick();
    check_eq("busy_start_reads", 64'(rd_addr_q.size() - r0), 4);
    check_eq("busy_start_y_cnt", 64'(y_cyc_q.size() - y0), 54);
    check_eq("busy_start_done", 64'(done_cnt - d0), 1);
    check_eq("busy_start_cnt", 64'(sample_cnt), 4);

    // Reset in the middle of the flush
    d0 = done_cnt;
    push_stream(2);
    start_stream(2, 0);
    repeat (10) tick();
    check_eq("flush_busy_before_rst", 64'(busy), 1);
    rst = 1'b1;
    tick();
    check_zero("midrst");
    rst = 1'b0;
    y0 = y_cyc_q.size();
    repeat (10) tick();
    check_eq("midrst_no_y", 64'(y_cyc_q.size() - y0), 0);
    check_eq("midrst_no_done", 64'(done_cnt - d0), 0);
    exp_q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
